// File: rtl/moore_vector_driver.sv
// Self-test initiator for the 3-bit-code / 2-bit-response Moore decoder: walks
// the code/select vectors, checks K against a golden model, and reports a verdict.
module moore_vector_driver #(
  parameter int unsigned SEL_SWEEP     = 1,
  parameter int unsigned STOP_ON_ERROR = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] K_in,
  output logic [2:0] E,
  output logic [1:0] select,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic [4:0] first_err_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] IDX_STEP = (SEL_SWEEP != 0) ? 5'd1 : 5'd4;
  localparam logic [4:0] IDX_LAST = (SEL_SWEEP != 0) ? 5'd31 : 5'd28;
  localparam logic       STOP_EN  = (STOP_ON_ERROR != 0);

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [5:0] err_count_q, err_count_d;
  logic [4:0] first_err_idx_q, first_err_idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic [1:0] exp_k;
  logic       mismatch;

  // Golden response for the vector currently held on E/select.
  always_comb begin
    exp_k = 2'b00;
    if (idx_q[4:2] == 3'b000) begin
      exp_k = 2'b00;
    end else if (idx_q[4]) begin
      exp_k = idx_q[1:0];
    end else begin
      exp_k = idx_q[3:2];
    end
  end

  assign mismatch = (K_in != exp_k);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    busy_d          = busy_q;
    done_d          = done_q;
    pass_d          = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d         = APPLY;
          idx_d           = 5'd0;
          err_count_d     = 6'd0;
          first_err_idx_d = 5'd0;
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
        end
      end
      APPLY: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          err_count_d = err_count_q + 6'd1;
          if (err_count_q == 6'd0) begin
            first_err_idx_d = idx_q;
          end
        end
        // The verdict uses the count including this vector's result.
        if ((idx_q == IDX_LAST) || (STOP_EN && mismatch)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 6'd0);
        end else begin
          idx_d   = idx_q + IDX_STEP;
          state_d = APPLY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      idx_q           <= 5'd0;
      err_count_q     <= 6'd0;
      first_err_idx_q <= 5'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  assign E             = idx_q[4:2];
  assign select        = idx_q[1:0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_moore_vector_driver.sv
// Directed bench for moore_vector_driver: three parameter variants, each wired
// to a behavioural decoder that can be switched to a stuck-at-00 response.
module tb_moore_vector_driver;

  logic clk;
  logic reset;
  logic start;
  logic k_stuck;

  int assert_count;
  int fail_count;

  logic [2:0] e_a, e_b, e_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic [1:0] k_a, k_b, k_c;
  logic [2:0] e_reg_a, e_reg_b, e_reg_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       pass_a, pass_b, pass_c;
  logic [5:0] err_a, err_b, err_c;
  logic [4:0] first_a, first_b, first_c;

  function automatic logic [1:0] golden_k(input logic [2:0] e, input logic [1:0] s);
    if (e == 3'b000) return 2'b00;
    else if (e[2]) return s;
    else return e[1:0];
  endfunction

  // Decoder stand-ins: E is registered, K is combinational against live select.
  always @(posedge clk) begin
    e_reg_a <= e_a;
    e_reg_b <= e_b;
    e_reg_c <= e_c;
  end

  assign k_a = k_stuck ? 2'b00 : golden_k(e_reg_a, sel_a);
  assign k_b = k_stuck ? 2'b00 : golden_k(e_reg_b, sel_b);
  assign k_c = k_stuck ? 2'b00 : golden_k(e_reg_c, sel_c);

  moore_vector_driver #(.SEL_SWEEP(1), .STOP_ON_ERROR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .K_in(k_a),
    .E(e_a), .select(sel_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_idx(first_a)
  );

  moore_vector_driver #(.SEL_SWEEP(0), .STOP_ON_ERROR(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .K_in(k_b),
    .E(e_b), .select(sel_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_idx(first_b)
  );

  moore_vector_driver #(.SEL_SWEEP(1), .STOP_ON_ERROR(1)) dut_c (
    .clk(clk), .reset(reset), .start(start), .K_in(k_c),
    .E(e_c), .select(sel_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .first_err_idx(first_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Start is driven at a negedge, so the sampling edge t0 is the next posedge.
  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    k_stuck = 1'b0;
    @(negedge clk);
    @(negedge clk);

    checkOutput("rst_E", 32'(e_a), 32'd0);
    checkOutput("rst_select", 32'(sel_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_pass", 32'(pass_a), 32'd0);
    checkOutput("rst_err_count", 32'(err_a), 32'd0);
    checkOutput("rst_first_err", 32'(first_a), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Stuck decoder, then abort the run with reset part-way through.
    k_stuck = 1'b1;
    applyStimulus();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 9) checkOutput("stop_done_early", 32'(done_c), 32'd0);
      if (cyc == 10) begin
        checkOutput("stop_done", 32'(done_c), 32'd1);
        checkOutput("stop_pass", 32'(pass_c), 32'd0);
        checkOutput("stop_err_count", 32'(err_c), 32'd1);
        checkOutput("stop_first_err", 32'(first_c), 32'd4);
        checkOutput("stop_E_held", 32'(e_c), 32'd1);
        checkOutput("stop_select_held", 32'(sel_c), 32'd0);
        checkOutput("stop_busy", 32'(busy_c), 32'd0);
      end
      if (cyc == 15) checkOutput("nosweep_done_early", 32'(done_b), 32'd0);
      if (cyc == 16) begin
        checkOutput("nosweep_done", 32'(done_b), 32'd1);
        checkOutput("nosweep_pass", 32'(pass_b), 32'd0);
        checkOutput("nosweep_err_count", 32'(err_b), 32'd3);
        checkOutput("nosweep_first_err", 32'(first_b), 32'd4);
      end
    end
    checkOutput("midrun_err_count", 32'(err_a), 32'd6);
    checkOutput("midrun_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy_a), 32'd0);
    checkOutput("abort_done", 32'(done_a), 32'd0);
    checkOutput("abort_pass", 32'(pass_a), 32'd0);
    checkOutput("abort_err_count", 32'(err_a), 32'd0);
    checkOutput("abort_first_err", 32'(first_a), 32'd0);
    checkOutput("abort_E", 32'(e_a), 32'd0);
    checkOutput("abort_select", 32'(sel_a), 32'd0);
    checkOutput("abort_done_c", 32'(done_c), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Clean run with a correct decoder; a start pulse mid-run must be ignored.
    k_stuck = 1'b0;
    applyStimulus();
    checkOutput("clean_busy_t0", 32'(busy_a), 32'd1);
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(negedge clk);
      if (cyc % 2 == 1) checkOutput("clean_vector", 32'({e_a, sel_a}), 32'((cyc - 1) / 2));
      if (cyc == 16) begin
        checkOutput("clean_nosweep_done", 32'(done_b), 32'd1);
        checkOutput("clean_nosweep_pass", 32'(pass_b), 32'd1);
      end
      if (cyc == 63) begin
        checkOutput("clean_busy_last", 32'(busy_a), 32'd1);
        checkOutput("clean_done_early", 32'(done_a), 32'd0);
      end
      if (cyc == 29) start = 1'b1;
      if (cyc == 30) start = 1'b0;
    end
    checkOutput("clean_done", 32'(done_a), 32'd1);
    checkOutput("clean_busy", 32'(busy_a), 32'd0);
    checkOutput("clean_pass", 32'(pass_a), 32'd1);
    checkOutput("clean_err_count", 32'(err_a), 32'd0);
    checkOutput("clean_stop_done", 32'(done_c), 32'd1);
    checkOutput("clean_stop_pass", 32'(pass_c), 32'd1);

    // Full sweep against a stuck-at-00 decoder.
    k_stuck = 1'b1;
    applyStimulus();
    repeat (63) @(negedge clk);
    checkOutput("stuck_done_early", 32'(done_a), 32'd0);
    @(negedge clk);
    checkOutput("stuck_done", 32'(done_a), 32'd1);
    checkOutput("stuck_pass", 32'(pass_a), 32'd0);
    checkOutput("stuck_err_count", 32'(err_a), 32'd24);
    checkOutput("stuck_first_err", 32'(first_a), 32'd4);

    // Start held in DONE restarts and clears the previous verdict.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_done", 32'(done_a), 32'd0);
    checkOutput("restart_busy", 32'(busy_a), 32'd1);
    checkOutput("restart_err_count", 32'(err_a), 32'd0);
    checkOutput("restart_first_err", 32'(first_a), 32'd0);
    checkOutput("restart_pass", 32'(pass_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
